dualmem_narrow_reader: RTL

//  Drains the 64-bit side of a widening dual-port buffer (1-cycle read latency) and presents
//  the contents as a 16-bit valid/ready stream. Typical uses are Ethernet TX and SD write

---
 rtl/dualmem_pkg.sv | 34 +++
 rtl/gearbox_64to16.sv | 80 ++++++++
 rtl/dualmem_narrow_reader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dualmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dualmem_pkg
// Description : Shared types and helpers for the 64-bit to 16-bit buffer reader.
//               Holds the FSM state encoding, the lane count and the lane slicer.
// Revision    : 1.0 - initial release
// ============================================================================
package dualmem_pkg;

  localparam int unsigned c_LANES  = 4;
  localparam int unsigned c_LANE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // Halfword k of a buffer word is bits [16k+15:16k]; lane 0 goes out first.
  function automatic logic [c_LANE_W-1:0] lane_sel(input logic [63:0] i_word,
                                                   input logic [1:0]  i_lane);
    logic [c_LANE_W-1:0] w_hw;
    case (i_lane)
      2'd0:    w_hw = i_word[15:0];
      2'd1:    w_hw = i_word[31:16];
      2'd2:    w_hw = i_word[47:32];
      default: w_hw = i_word[63:48];
    endcase
    return w_hw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gearbox_64to16.sv
`default_nettype none
// ============================================================================
// Module      : gearbox_64to16
// Description : Two-deep word buffer (cur/nxt) serialising 64-bit read data into
//               a 16-bit valid/ready stream, lowest lane first, with last tagging.
// Revision    : 1.0 - initial release
// ============================================================================
module gearbox_64to16
  import dualmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rd_vld,     // read data returning this cycle
  input  logic [63:0] i_rd_data,
  input  logic        i_last_hw,    // the halfword now on the bus is the final one
  input  logic        i_ready,
  output logic        o_valid,
  output logic [15:0] o_data,
  output logic        o_last,
  output logic        o_hs,
  output logic        o_nxt_free    // nxt is empty or will be empty after this cycle
);

  logic [63:0] r_cur;
  logic [63:0] r_nxt;
  logic        r_cur_vld;
  logic        r_nxt_vld;
  logic [1:0]  r_lane;

  logic        w_hs;
  logic        w_cur_done;
  logic        w_cur_load;

  assign w_hs       = r_cur_vld & i_ready;
  // cur retires after its top lane, or early on the final halfword of a partial word
  assign w_cur_done = w_hs & ((r_lane == 2'(c_LANES - 1)) | i_last_hw);
  assign w_cur_load = ~r_cur_vld | w_cur_done;

  assign o_valid    = r_cur_vld;
  assign o_data     = lane_sel(r_cur, r_lane);
  assign o_last     = r_cur_vld & i_last_hw;
  assign o_hs       = w_hs;
  assign o_nxt_free = ~r_nxt_vld | w_cur_done;

  // Refill cur from nxt (or straight from read data), otherwise advance the lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur     <= '0;
      r_nxt     <= '0;
      r_cur_vld <= 1'b0;
      r_nxt_vld <= 1'b0;
      r_lane    <= '0;
    end else if (w_cur_load) begin
      r_lane <= '0;
      if (r_nxt_vld) begin
        r_cur     <= r_nxt;
        r_cur_vld <= 1'b1;
        r_nxt_vld <= i_rd_vld;
        if (i_rd_vld) begin
          r_nxt <= i_rd_data;
        end
      end else if (i_rd_vld) begin
        r_cur     <= i_rd_data;
        r_cur_vld <= 1'b1;
      end else begin
        r_cur_vld <= 1'b0;
      end
    end else begin
      if (w_hs) begin
        r_lane <= r_lane + 2'd1;
      end
      if (i_rd_vld) begin
        r_nxt     <= i_rd_data;
        r_nxt_vld <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dualmem_narrow_reader.sv
`default_nettype none
// ============================================================================
// Module      : dualmem_narrow_reader
// Description : Drains the 64-bit read port of a dual-port buffer and presents
//               the frame as a 16-bit valid/ready stream. Holds the control FSM,
//               the word/halfword counters and the read issue logic.
// Revision    : 1.0 - initial release
// ============================================================================
module dualmem_narrow_reader
  import dualmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned LEN_W  = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [63:0]       i_mem_rdata,
  output logic [15:0]       o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_tx_last
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_addr;
  logic [LEN_W-2:0]   r_words;     // reads still to issue
  logic [LEN_W-1:0]   r_rem;       // halfwords still to hand over
  logic               r_rd_pend;   // read issued last cycle, data arrives now
  logic               r_done;

  logic               w_mem_en;
  logic               w_hs;
  logic               w_nxt_free;
  logic               w_last_hw;
  logic               w_accept;
  logic [LEN_W-2:0]   w_words_init;

  // ceil(len/4) without widening: whole words plus one for a partial tail
  assign w_words_init = {1'b0, i_len[LEN_W-1:2]} + {{(LEN_W-2){1'b0}}, |i_len[1:0]};
  assign w_accept     = (r_state == ST_IDLE) & i_start;
  assign w_last_hw    = (r_rem == LEN_W'(1));

  // Next-state decode and read issue.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_len == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        w_mem_en = (r_words != '0) & ~r_rd_pend & w_nxt_free;
        if (w_mem_en && (r_words == (LEN_W-1)'(1))) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_hs && w_last_hw) begin
          w_state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Address, counters, outstanding-read flag and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_words   <= '0;
      r_rem     <= '0;
      r_rd_pend <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rd_pend <= w_mem_en;
      r_done    <= (r_state == ST_FIN);
      if (w_accept) begin
        r_addr  <= i_base_addr;
        r_words <= w_words_init;
        r_rem   <= i_len;
      end else begin
        if (w_mem_en) begin
          r_addr  <= r_addr + ADDR_W'(1);
          r_words <= r_words - (LEN_W-1)'(1);
        end
        if (w_hs && (r_rem != '0)) begin
          r_rem <= r_rem - LEN_W'(1);
        end
      end
    end
  end

  gearbox_64to16 u_gearbox (
    .clk        (clk),
    .rst        (rst),
    .i_rd_vld   (r_rd_pend),
    .i_rd_data  (i_mem_rdata),
    .i_last_hw  (w_last_hw),
    .i_ready    (i_tx_ready),
    .o_valid    (o_tx_valid),
    .o_data     (o_tx_data),
    .o_last     (o_tx_last),
    .o_hs       (w_hs),
    .o_nxt_free (w_nxt_free)
  );

  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = r_done;
  assign o_mem_en   = w_mem_en;
  assign o_mem_addr = r_addr;

endmodule
`default_nettype wire
